// File: rtl/ram_scalar_port_b_arbiter.sv
// Round-robin arbiter with locked bursts for scalar RAM port B; registered command stage, read data tagged back per requester.
// Latency: gnt is combinational, the RAM command follows 1 cycle later, rvalid READ_LATENCY+1 cycles after gnt; a requester waits by holding req until gnt.
module ram_scalar_port_b_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 24,
  parameter int READ_LATENCY = 2,
  parameter int MAX_BURST    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] ram_address_b,
  output logic [DATA_W-1:0] ram_data_b,
  output logic              ram_rden_b,
  output logic              ram_wren_b,
  input  logic [DATA_W-1:0] ram_q_b
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  // Owner keeps the bus while cnt < BURST_LAST; the grant at cnt == BURST_LAST is its last.
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  state_t     state, state_nxt;
  logic       ptr, ptr_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [1:0] req, lock, gnt_raw, gnt;
  logic       arb_en, arb_ptr, own, win;
  cmd_t       cmd0, cmd1, sel_cmd;

  logic [READ_LATENCY-1:0] pipe_vld;
  logic [READ_LATENCY-1:0] pipe_id;
  logic                    tail_vld, tail_id;

  assign req  = {m1_req, m1_lock & 1'b0} | {1'b0, m0_req};
  assign lock = {m1_lock, m0_lock};

  always_comb begin
    gnt_raw   = 2'b00;
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    arb_en    = 1'b1;
    arb_ptr   = ptr;
    own       = 1'b0;
    win       = 1'b0;
    if (state != IDLE) begin
      own = (state == OWN1);
      if (req[own]) begin
        // The owner wins its exit cycle too; the other side gets priority afterwards.
        gnt_raw[own] = 1'b1;
        arb_en       = 1'b0;
        if (lock[own] && (cnt < BURST_LAST)) begin
          cnt_nxt = cnt + 4'd1;
        end else begin
          state_nxt = IDLE;
          ptr_nxt   = ~own;
          cnt_nxt   = '0;
        end
      end else begin
        state_nxt = IDLE;
        ptr_nxt   = ~own;
        cnt_nxt   = '0;
        arb_ptr   = ~own;
      end
    end
    if (arb_en && (req != 2'b00)) begin
      win          = (req == 2'b11) ? arb_ptr : req[1];
      gnt_raw[win] = 1'b1;
      if (lock[win] && (MAX_BURST > 1)) begin
        state_nxt = win ? OWN1 : OWN0;
        cnt_nxt   = 4'd1;
      end else begin
        state_nxt = IDLE;
        ptr_nxt   = ~win;
        cnt_nxt   = '0;
      end
    end
  end

  // Grants are held off while reset is asserted so every output reads 0.
  assign gnt    = gnt_raw & {2{rst_n}};
  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign cmd0    = '{we: m0_we, addr: m0_addr, wdata: m0_wdata};
  assign cmd1    = '{we: m1_we, addr: m1_addr, wdata: m1_wdata};
  assign sel_cmd = gnt[1] ? cmd1 : cmd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_address_b <= '0;
      ram_data_b    <= '0;
      ram_rden_b    <= 1'b0;
      ram_wren_b    <= 1'b0;
    end else begin
      ram_rden_b <= (|gnt) & ~sel_cmd.we;
      ram_wren_b <= (|gnt) & sel_cmd.we;
      if (|gnt) begin
        ram_address_b <= sel_cmd.addr;
        ram_data_b    <= sel_cmd.wdata;
      end
    end
  end

  // Slot 0 lines up with the command on the RAM pins; the tail lines up with valid q_b.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      pipe_id  <= '0;
    end else begin
      pipe_vld[0] <= (|gnt) & ~sel_cmd.we;
      pipe_id[0]  <= gnt[1];
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_id[i]  <= pipe_id[i-1];
      end
    end
  end

  assign tail_vld = pipe_vld[READ_LATENCY-1];
  assign tail_id  = pipe_id[READ_LATENCY-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= tail_vld & ~tail_id;
      m1_rvalid <= tail_vld & tail_id;
      if (tail_vld && !tail_id) m0_rdata <= ram_q_b;
      if (tail_vld && tail_id)  m1_rdata <= ram_q_b;
    end
  end

endmodule

// File: tb/tb_ram_scalar_port_b_arbiter.sv
// Directed bench for ram_scalar_port_b_arbiter with a 1-register RAM model (READ_LATENCY=2).
module tb_ram_scalar_port_b_arbiter;

  localparam int AW = 14;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] ram_address_b;
  logic [DW-1:0] ram_data_b;
  logic          ram_rden_b, ram_wren_b;
  logic [DW-1:0] ram_q_b = '0;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          mem_init = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  ram_scalar_port_b_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(2), .MAX_BURST(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_address_b(ram_address_b), .ram_data_b(ram_data_b),
    .ram_rden_b(ram_rden_b), .ram_wren_b(ram_wren_b), .ram_q_b(ram_q_b)
  );

  always #5 clk = ~clk;

  // RAM samples the command at the edge and presents q_b one cycle later.
  always @(posedge clk) begin
    if (!mem_init) begin
      mem[1]   <= 24'h666666;
      mem[2]   <= 24'h222222;
      mem[3]   <= 24'h333333;
      mem_init <= 1'b1;
    end else begin
      if (ram_wren_b) mem[ram_address_b] <= ram_data_b;
      if (ram_rden_b) ram_q_b <= mem[ram_address_b];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r0, input logic w0, input logic l0,
                       input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, input logic w1, input logic l1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    m0_req = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    idle();
    // Reset values, with both requesters asking while reset is held
    repeat (2) cyc();
    m0_req = 1'b1; m1_req = 1'b1;
    #1;
    check("rst_gnt0",   32'(m0_gnt), 32'd0);
    check("rst_gnt1",   32'(m1_gnt), 32'd0);
    check("rst_rden",   32'(ram_rden_b), 32'd0);
    check("rst_wren",   32'(ram_wren_b), 32'd0);
    check("rst_addr",   32'(ram_address_b), 32'd0);
    check("rst_rvalid0", 32'(m0_rvalid), 32'd0);
    check("rst_rvalid1", 32'(m1_rvalid), 32'd0);
    check("rst_rdata0", 32'(m0_rdata), 32'd0);
    check("rst_rdata1", 32'(m1_rdata), 32'd0);
    idle();
    rst_n = 1'b1;

    // Single read by m0 from address 1
    cyc(); drive(1'b1, 1'b0, 1'b0, 14'h1, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    check("rd_gnt0", 32'(m0_gnt), 32'd1);
    check("rd_gnt1", 32'(m1_gnt), 32'd0);
    cyc(); idle();
    check("rd_cmd_rden", 32'(ram_rden_b), 32'd1);
    check("rd_cmd_wren", 32'(ram_wren_b), 32'd0);
    check("rd_cmd_addr", 32'(ram_address_b), 32'h1);
    cyc();
    check("rd_early_rvalid0", 32'(m0_rvalid), 32'd0);
    cyc();
    check("rd_rvalid0", 32'(m0_rvalid), 32'd1);
    check("rd_rdata0",  32'(m0_rdata), 32'h666666);
    check("rd_rvalid1", 32'(m1_rvalid), 32'd0);
    cyc();
    check("rd_pulse_end0", 32'(m0_rvalid), 32'd0);

    // m1 writes address 1, then reads it back
    cyc(); drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 14'h1, 24'h888888);
    check("wr_gnt1", 32'(m1_gnt), 32'd1);
    cyc(); drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 14'h1, '0);
    check("wrrd_gnt1",   32'(m1_gnt), 32'd1);
    check("wr_cmd_wren", 32'(ram_wren_b), 32'd1);
    check("wr_cmd_rden", 32'(ram_rden_b), 32'd0);
    check("wr_cmd_data", 32'(ram_data_b), 32'h888888);
    cyc(); idle();
    check("wrrd_cmd_rden", 32'(ram_rden_b), 32'd1);
    check("wrrd_cmd_wren", 32'(ram_wren_b), 32'd0);
    cyc();
    check("wr_no_rvalid1", 32'(m1_rvalid), 32'd0);
    cyc();
    check("wrrd_rvalid1", 32'(m1_rvalid), 32'd1);
    check("wrrd_rdata1",  32'(m1_rdata), 32'h888888);
    check("wrrd_rvalid0", 32'(m0_rvalid), 32'd0);
    check("hold_rdata0",  32'(m0_rdata), 32'h666666);

    // Round robin: both read continuously for 4 cycles, no lock
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (k < 4) begin
        drive(1'b1, 1'b0, 1'b0, 14'h2, '0, 1'b1, 1'b0, 1'b0, 14'h3, '0);
        check($sformatf("rr_gnt0_%0d", k), 32'(m0_gnt), 32'((k % 2) == 0));
        check($sformatf("rr_gnt1_%0d", k), 32'(m1_gnt), 32'((k % 2) == 1));
      end else begin
        idle();
      end
      check($sformatf("rr_rvalid0_%0d", k), 32'(m0_rvalid), 32'(k == 3 || k == 5));
      check($sformatf("rr_rvalid1_%0d", k), 32'(m1_rvalid), 32'(k == 4 || k == 6));
      if (k == 3 || k == 5) check($sformatf("rr_rdata0_%0d", k), 32'(m0_rdata), 32'h222222);
      if (k == 4 || k == 6) check($sformatf("rr_rdata1_%0d", k), 32'(m1_rdata), 32'h333333);
    end

    // Reset pulse with an m0 read in flight
    cyc(); drive(1'b1, 1'b0, 1'b0, 14'h2, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    check("ifr_gnt0", 32'(m0_gnt), 32'd1);
    cyc(); idle();
    check("ifr_cmd_rden", 32'(ram_rden_b), 32'd1);
    rst_n = 1'b0;
    #1;
    check("ifr_rst_rden",  32'(ram_rden_b), 32'd0);
    check("ifr_rst_addr",  32'(ram_address_b), 32'd0);
    check("ifr_rst_rdata0", 32'(m0_rdata), 32'd0);
    rst_n = 1'b1;
    cyc(); drive(1'b1, 1'b0, 1'b0, 14'h2, '0, 1'b1, 1'b0, 1'b0, 14'h3, '0);
    check("ifr_first_gnt0", 32'(m0_gnt), 32'd1);
    check("ifr_first_gnt1", 32'(m1_gnt), 32'd0);
    check("ifr_drop_a", 32'(m0_rvalid), 32'd0);
    cyc(); idle();
    check("ifr_drop_b", 32'(m0_rvalid), 32'd0);
    cyc();
    check("ifr_drop_c", 32'(m0_rvalid), 32'd0);
    cyc();
    check("ifr_new_rvalid0", 32'(m0_rvalid), 32'd1);
    check("ifr_new_rdata0",  32'(m0_rdata), 32'h222222);

    // Locked burst by m1 while m0 also requests
    for (int k = 0; k < 9; k++) begin
      cyc(); drive(1'b1, 1'b0, 1'b0, 14'h2, '0, 1'b1, 1'b0, 1'b1, 14'h3, '0);
      check($sformatf("burst_gnt1_%0d", k), 32'(m1_gnt), 32'(k < 8));
      check($sformatf("burst_gnt0_%0d", k), 32'(m0_gnt), 32'(k == 8));
    end
    cyc(); idle();
    repeat (4) cyc();

    // m0 locks for 3 grants, then drops lock on the 4th
    for (int k = 0; k < 5; k++) begin
      cyc(); drive(1'b1, 1'b0, logic'(k < 3), 14'h2, '0, logic'(k > 0), 1'b0, 1'b0, 14'h3, '0);
      check($sformatf("rel_gnt0_%0d", k), 32'(m0_gnt), 32'(k < 4));
      check($sformatf("rel_gnt1_%0d", k), 32'(m1_gnt), 32'(k == 4));
    end
    cyc(); idle();
    repeat (4) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
